spi_slave_core: RTL and testbench

SPI_SLAVE_CORE -- requirements
Module: spi_slave_core

---
 rtl/spi_slave_core.sv | 135 +++++++++++++
 tb/tb_spi_slave_core.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_core.sv
// SPI slave with clk-domain oversampling of SCK/SSEL/MOSI.
// Single-word TX holding register and RX output register with handshakes.
module spi_slave_core #(
    parameter int              WIDTH   = 8,
    parameter bit              CPOL    = 1'b0,
    parameter bit              CPHA    = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_TX = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             SCK,
    input  logic             SSEL,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             rx_overrun,
    output logic             tx_underrun,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    logic [2:0]       sck_q;
    logic [2:0]       sel_q;
    logic [1:0]       mosi_q;
    logic [2:0]       fill;
    logic             armed;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rx_sh;
    logic [WIDTH-1:0] tx_sh;
    logic [WIDTH-1:0] hold;
    logic             full;

    logic active, start, rise, fall, lead, trail;
    logic sample, shift_e, last, done, load, do_shift, write;

    // sel_q holds the inverted select so a cleared synchroniser reads as idle
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q  <= '0;
            sel_q  <= '0;
            mosi_q <= '0;
            fill   <= '0;
            armed  <= 1'b0;
        end else begin
            sck_q  <= {sck_q[1:0], SCK};
            sel_q  <= {sel_q[1:0], ~SSEL};
            mosi_q <= {mosi_q[0], MOSI};
            fill   <= {fill[1:0], 1'b1};
            // a transfer may only start once SSEL has been seen idle after reset
            if (fill[2] && !sel_q[1])
                armed <= 1'b1;
        end
    end

    always_comb begin
        active   = armed & sel_q[1];
        start    = active & ~sel_q[2];
        rise     = sck_q[1] & ~sck_q[2];
        fall     = ~sck_q[1] & sck_q[2];
        lead     = CPOL ? fall : rise;
        trail    = CPOL ? rise : fall;
        sample   = active & ~start & (CPHA ? trail : lead);
        shift_e  = active & ~start & (CPHA ? lead : trail);
        last     = (cnt == CW'(WIDTH - 1));
        done     = sample & last;
        // counter at 0 on a shift edge: reload slot (CPHA=0) or bit-0 lead (CPHA=1)
        load     = start | (shift_e & (cnt == '0) & ~CPHA) | (done & CPHA);
        do_shift = shift_e & (cnt != '0);
        write    = tx_valid & ~full;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            rx_sh <= '0;
        end else if (!active || start) begin
            cnt   <= '0;
            rx_sh <= '0;
        end else if (sample) begin
            rx_sh <= {rx_sh[WIDTH-2:0], mosi_q[1]};
            cnt   <= last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (done) begin
                rx_data    <= {rx_sh[WIDTH-2:0], mosi_q[1]};
                rx_valid   <= 1'b1;
                rx_overrun <= rx_valid & ~rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sh       <= '0;
            hold        <= '0;
            full        <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (load) begin
                tx_sh       <= full ? hold : IDLE_TX;
                tx_underrun <= ~full;
            end else if (do_shift) begin
                tx_sh <= {tx_sh[WIDTH-2:0], 1'b0};
            end
            if (write) begin
                hold <= tx_data;
                full <= 1'b1;
            end else if (load) begin
                full <= 1'b0;
            end
        end
    end

    assign MISO     = active & tx_sh[WIDTH-1];
    assign tx_ready = ~full;
    assign busy     = active;

endmodule

// File: tb/tb_spi_slave_core.sv
// Scoreboard bench: four DUTs, one per SPI mode, driven by a bit-level master.
// Expected RX words and MISO words are queued; a monitor checks the outputs.
module tb_spi_slave_core;

    localparam int HP = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck [4];
    logic       ssel [4];
    logic       mosi [4];
    logic       miso [4];
    logic [7:0] tx_data [4];
    logic       tx_valid [4];
    logic       tx_ready [4];
    logic [7:0] rx_data [4];
    logic       rx_valid [4];
    logic       rx_ready [4];
    logic       rx_overrun [4];
    logic       tx_underrun [4];
    logic       busy [4];

    logic [7:0] rxq [4][$];
    logic [7:0] txq [4][$];
    logic [7:0] cap [4];
    int         ov_cnt [4];
    int         ur_cnt [4];
    int         vec = 0;
    int         errs = 0;
    bit         rdy_off = 1'b0;
    bit         rnd_rdy = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_slave_core #(
            .WIDTH(8),
            .CPOL(g >= 2),
            .CPHA(g % 2 == 1)
        ) dut (
            .clk(clk),
            .rst(rst),
            .SCK(sck[g]),
            .SSEL(ssel[g]),
            .MOSI(mosi[g]),
            .MISO(miso[g]),
            .tx_data(tx_data[g]),
            .tx_valid(tx_valid[g]),
            .tx_ready(tx_ready[g]),
            .rx_data(rx_data[g]),
            .rx_valid(rx_valid[g]),
            .rx_ready(rx_ready[g]),
            .rx_overrun(rx_overrun[g]),
            .tx_underrun(tx_underrun[g]),
            .busy(busy[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // consumer: rx_ready forced low, high, or random
    always begin
        @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            if (m == 0 && rdy_off)
                rx_ready[m] = 1'b0;
            else if (rnd_rdy)
                rx_ready[m] = 1'($urandom_range(0, 1));
            else
                rx_ready[m] = 1'b1;
        end
    end

    // monitor: pops expected RX words on each accepted handshake
    always @(negedge clk) begin
        if (!rst) begin
            for (int m = 0; m < 4; m++) begin
                if (rx_overrun[m])
                    ov_cnt[m]++;
                if (tx_underrun[m])
                    ur_cnt[m]++;
                if (rx_valid[m] && rx_ready[m]) begin
                    if (rxq[m].size() == 0) begin
                        vec++;
                        errs++;
                        $display("FAIL rx_unexpected: mode %0d got %0h expected none",
                                 m, rx_data[m]);
                    end else begin
                        chk($sformatf("rx_data_m%0d", m), 32'(rx_data[m]),
                            32'(rxq[m].pop_front()));
                    end
                end
            end
        end
    end

    task automatic ssel_low(input int m);
        ssel[m] = 1'b0;
        wait_clk(8);
    endtask

    task automatic ssel_high(input int m);
        wait_clk(8);
        ssel[m] = 1'b1;
        wait_clk(8);
    endtask

    // reference master: sends n bits from d MSB first, captures MISO at sample edges
    task automatic xfer_bits(input int m, input logic [7:0] d, input int n);
        logic cpol;
        logic cpha;
        logic [7:0] sh;
        cpol = (m >= 2);
        cpha = (m % 2 == 1);
        sh = d;
        for (int i = 0; i < n; i++) begin
            if (!cpha) begin
                mosi[m] = sh[7];
                wait_clk(HP);
                sck[m] = ~cpol;
                cap[m] = {cap[m][6:0], miso[m]};
                wait_clk(HP);
                sck[m] = cpol;
            end else begin
                wait_clk(HP);
                sck[m] = ~cpol;
                mosi[m] = sh[7];
                wait_clk(HP);
                sck[m] = cpol;
                cap[m] = {cap[m][6:0], miso[m]};
            end
            sh = sh << 1;
        end
    endtask

    task automatic miso_check(input int m);
        if (txq[m].size() == 0) begin
            vec++;
            errs++;
            $display("FAIL miso_m%0d: got %0h expected none", m, cap[m]);
        end else begin
            chk($sformatf("miso_m%0d", m), 32'(cap[m]), 32'(txq[m].pop_front()));
        end
    endtask

    task automatic xfer_word(input int m, input logic [7:0] d);
        cap[m] = '0;
        rxq[m].push_back(d);
        xfer_bits(m, d, 8);
        miso_check(m);
    endtask

    task automatic feed(input int m, input logic [7:0] d);
        int t;
        t = 0;
        while (!tx_ready[m] && t < 3000) begin
            wait_clk(1);
            t++;
        end
        if (t >= 3000) begin
            vec++;
            errs++;
            $display("FAIL feed_timeout: mode %0d tx_ready 0 expected 1", m);
        end else begin
            tx_data[m]  = d;
            tx_valid[m] = 1'b1;
            wait_clk(1);
            tx_valid[m] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t expected completion", $time);
        $fatal(1);
    end

    initial begin
        int ov0;
        int ur0;
        int t;
        logic [7:0] tw [4];
        logic [7:0] rw [4];
        for (int m = 0; m < 4; m++) begin
            sck[m]      = (m >= 2);
            ssel[m]     = 1'b1;
            mosi[m]     = 1'b0;
            tx_data[m]  = '0;
            tx_valid[m] = 1'b0;
            cap[m]      = '0;
            ov_cnt[m]   = 0;
            ur_cnt[m]   = 0;
        end
        rst = 1'b1;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(1);
        chk("reset_tx_ready", 32'(tx_ready[0]), 32'd1);
        chk("reset_busy", 32'(busy[0]), 32'd0);
        chk("reset_miso", 32'(miso[0]), 32'd0);
        chk("reset_rx_valid", 32'(rx_valid[0]), 32'd0);
        wait_clk(10);

        // basic mode 0 exchange
        txq[0].push_back(8'hA5);
        feed(0, 8'hA5);
        chk("full_tx_ready", 32'(tx_ready[0]), 32'd0);
        ssel_low(0);
        chk("start_tx_ready", 32'(tx_ready[0]), 32'd1);
        chk("start_busy", 32'(busy[0]), 32'd1);
        xfer_word(0, 8'h3C);
        ssel_high(0);
        wait_clk(10);

        // no TX word: idle pattern and a single underrun at start
        ur0 = ur_cnt[0];
        txq[0].push_back(8'hFF);
        ssel_low(0);
        cap[0] = '0;
        rxq[0].push_back(8'h5A);
        xfer_bits(0, 8'h5A, 7);
        chk("underrun_start", 32'(ur_cnt[0] - ur0), 32'd1);
        xfer_bits(0, 8'h00, 1);
        miso_check(0);
        ssel_high(0);
        wait_clk(10);

        // overrun with consumer stalled
        rdy_off = 1'b1;
        wait_clk(2);
        ov0 = ov_cnt[0];
        ssel_low(0);
        xfer_bits(0, 8'h11, 8);
        wait_clk(6);
        chk("ovr_first_data", 32'(rx_data[0]), 32'h11);
        chk("ovr_first_cnt", 32'(ov_cnt[0] - ov0), 32'd0);
        xfer_bits(0, 8'h22, 8);
        wait_clk(6);
        chk("ovr_data", 32'(rx_data[0]), 32'h22);
        chk("ovr_valid", 32'(rx_valid[0]), 32'd1);
        chk("ovr_cnt", 32'(ov_cnt[0] - ov0), 32'd1);
        ssel_high(0);
        rxq[0].push_back(8'h22);
        rdy_off = 1'b0;
        wait_clk(10);

        // partial word aborted by SSEL
        ssel_low(0);
        xfer_bits(0, 8'hF0, 5);
        ssel_high(0);
        chk("partial_valid", 32'(rx_valid[0]), 32'd0);
        txq[0].push_back(8'hFF);
        ssel_low(0);
        xfer_word(0, 8'h0F);
        ssel_high(0);
        wait_clk(10);
        chk("after_partial_data", 32'(rx_data[0]), 32'h0F);

        // all four modes, two words back to back with refills
        for (int m = 0; m < 4; m++) begin
            txq[m].push_back(8'h81);
            txq[m].push_back(8'h7E);
            fork
                begin
                    feed(m, 8'h81);
                    feed(m, 8'h7E);
                end
                begin
                    wait_clk(4);
                    ssel_low(m);
                    xfer_word(m, 8'h81);
                    xfer_word(m, 8'h7E);
                    ssel_high(m);
                end
            join
            wait_clk(10);
        end

        // randomized words in every mode with a random consumer
        rnd_rdy = 1'b1;
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) begin
                tw[i] = 8'($urandom);
                rw[i] = 8'($urandom);
                txq[m].push_back(tw[i]);
            end
            fork
                begin
                    for (int i = 0; i < 4; i++)
                        feed(m, tw[i]);
                end
                begin
                    wait_clk(4);
                    ssel_low(m);
                    for (int i = 0; i < 4; i++)
                        xfer_word(m, rw[i]);
                    ssel_high(m);
                end
            join
            wait_clk(10);
        end
        rnd_rdy = 1'b0;
        wait_clk(20);

        // reset in the middle of a transfer
        ssel_low(0);
        feed(0, 8'h99);
        xfer_bits(0, 8'hAA, 3);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        chk("mid_rst_rx_valid", 32'(rx_valid[0]), 32'd0);
        chk("mid_rst_rx_data", 32'(rx_data[0]), 32'd0);
        chk("mid_rst_tx_ready", 32'(tx_ready[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy[0]), 32'd0);
        chk("mid_rst_miso", 32'(miso[0]), 32'd0);
        chk("mid_rst_flags", 32'({rx_overrun[0], tx_underrun[0]}), 32'd0);
        ssel_high(0);
        txq[0].push_back(8'hFF);
        ssel_low(0);
        xfer_word(0, 8'h55);
        ssel_high(0);

        t = 0;
        while ((rxq[0].size() + rxq[1].size() + rxq[2].size()
                + rxq[3].size()) != 0 && t < 500) begin
            wait_clk(1);
            t++;
        end
        for (int m = 0; m < 4; m++) begin
            chk($sformatf("rxq_left_m%0d", m), 32'(rxq[m].size()), 32'd0);
            chk($sformatf("txq_left_m%0d", m), 32'(txq[m].size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
